// File: rtl/pe_os.sv
`default_nettype none
// ============================================================================
// Module   : pe_os
// Purpose  : Output-stationary processing element for a systolic
//            matrix-multiply array. Each cycle the incoming activation and
//            weight are multiplied and the product is added into a local
//            accumulator that stays in place. Operands are forwarded to the
//            right-hand (activation) and lower (weight) neighbours through
//            one register stage each.
// Ports    : clk_i      - clock, all state updates on the rising edge
//            rst_i      - synchronous active-high reset
//            clear_i    - synchronous active-high accumulator clear
//            active_i   - activation from left neighbour / array edge
//            weight_i   - weight from upper neighbour / array edge
//            active_o   - registered activation to the right neighbour
//            weight_o   - registered weight to the lower neighbour
//            mac_res_o  - accumulator value, driven straight from a register
// Revision : 1.0 - initial release
// ============================================================================
module pe_os #(
    parameter int DATA_WIDTH_IN  = 16,
    parameter int DATA_WIDTH_OUT = 32,
    parameter int SIGNED         = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic [DATA_WIDTH_IN-1:0]  active_i,
    input  logic [DATA_WIDTH_IN-1:0]  weight_i,
    output logic [DATA_WIDTH_IN-1:0]  active_o,
    output logic [DATA_WIDTH_IN-1:0]  weight_o,
    output logic [DATA_WIDTH_OUT-1:0] mac_res_o
);

    // Full-precision product width; the accumulator must be able to hold it.
    localparam int c_PROD_W = 2 * DATA_WIDTH_IN;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter check
    // ------------------------------------------------------------------------
    generate
        if (DATA_WIDTH_OUT < c_PROD_W) begin : g_width_check
            $error("pe_os: DATA_WIDTH_OUT must be >= 2*DATA_WIDTH_IN");
        end
    endgenerate

    logic [c_PROD_W-1:0]       w_op_a;      // activation extended to product width
    logic [c_PROD_W-1:0]       w_op_b;      // weight extended to product width
    logic [c_PROD_W-1:0]       w_prod;      // full-width product
    logic [DATA_WIDTH_OUT-1:0] w_prod_ext;  // product extended to accumulator width

    logic [DATA_WIDTH_IN-1:0]  r_active;
    logic [DATA_WIDTH_IN-1:0]  r_weight;
    logic [DATA_WIDTH_OUT-1:0] r_acc;

    // ------------------------------------------------------------------------
    // Combinational multiplier. Operands are widened to the full product
    // width before multiplying, so the low c_PROD_W bits of the multiply are
    // the exact product for either signedness. Operands come straight from
    // the inputs, not from the forwarding registers.
    // ------------------------------------------------------------------------
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_op_a     = c_PROD_W'($signed(active_i));
            assign w_op_b     = c_PROD_W'($signed(weight_i));
            assign w_prod     = w_op_a * w_op_b;
            assign w_prod_ext = DATA_WIDTH_OUT'($signed(w_prod));
        end else begin : g_unsigned
            assign w_op_a     = c_PROD_W'(active_i);
            assign w_op_b     = c_PROD_W'(weight_i);
            assign w_prod     = w_op_a * w_op_b;
            assign w_prod_ext = DATA_WIDTH_OUT'(w_prod);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Forwarding registers and accumulator. Reset overrides clear; clear only
    // affects the accumulator, forwarding continues regardless. The add
    // wraps silently modulo 2^DATA_WIDTH_OUT.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_active <= '0;
            r_weight <= '0;
            r_acc    <= '0;
        end else begin
            r_active <= active_i;
            r_weight <= weight_i;
            if (clear_i) begin
                r_acc <= '0;
            end else begin
                r_acc <= r_acc + w_prod_ext;
            end
        end
    end

    assign active_o  = r_active;
    assign weight_o  = r_weight;
    assign mac_res_o = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_pe_os.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_os
// Purpose  : Self-checking bench for pe_os. An unsigned and a signed
//            instance share the same stimulus. The driver predicts every
//            post-edge output from an arithmetic reference model and queues
//            it; a monitor pops one entry after every driven edge and
//            compares it with both instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_os;

    localparam int DW_IN  = 16;
    localparam int DW_OUT = 32;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              clear_i = 1'b0;
    logic [DW_IN-1:0]  active_i = '0;
    logic [DW_IN-1:0]  weight_i = '0;

    logic [DW_IN-1:0]  u_active_o, u_weight_o, s_active_o, s_weight_o;
    logic [DW_OUT-1:0] u_mac, s_mac;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW_IN-1:0]  act;
        logic [DW_IN-1:0]  wgt;
        logic [DW_OUT-1:0] acc_u;
        logic [DW_OUT-1:0] acc_s;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [DW_OUT-1:0] m_acc_u = '0;
    logic [DW_OUT-1:0] m_acc_s = '0;

    always #5 clk = ~clk;

    pe_os #(.DATA_WIDTH_IN(DW_IN), .DATA_WIDTH_OUT(DW_OUT), .SIGNED(0)) u_dut_u (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
        .active_i(active_i), .weight_i(weight_i),
        .active_o(u_active_o), .weight_o(u_weight_o), .mac_res_o(u_mac)
    );

    pe_os #(.DATA_WIDTH_IN(DW_IN), .DATA_WIDTH_OUT(DW_OUT), .SIGNED(1)) u_dut_s (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
        .active_i(active_i), .weight_i(weight_i),
        .active_o(s_active_o), .weight_o(s_weight_o), .mac_res_o(s_mac)
    );

    // Plain-arithmetic products, truncated to the accumulator width.
    function automatic logic [DW_OUT-1:0] prod_u(input logic [DW_IN-1:0] a,
                                                 input logic [DW_IN-1:0] w);
        longint pa, pw;
        pa = longint'(a);
        pw = longint'(w);
        return DW_OUT'(pa * pw);
    endfunction

    function automatic logic [DW_OUT-1:0] prod_s(input logic [DW_IN-1:0] a,
                                                 input logic [DW_IN-1:0] w);
        longint pa, pw;
        pa = longint'($signed(a));
        pw = longint'($signed(w));
        return DW_OUT'(pa * pw);
    endfunction

    task automatic cmp(input string name, input logic [DW_OUT-1:0] act,
                       input logic [DW_OUT-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Drive one edge: apply inputs at the falling edge, predict the outputs
    // after the following rising edge, then wait for that edge.
    task automatic step(input logic rst, input logic clr,
                        input logic [DW_IN-1:0] a, input logic [DW_IN-1:0] w);
        exp_t e;
        @(negedge clk);
        rst_i    = rst;
        clear_i  = clr;
        active_i = a;
        weight_i = w;
        if (rst) begin
            m_acc_u = '0;
            m_acc_s = '0;
            e.act   = '0;
            e.wgt   = '0;
        end else begin
            e.act = a;
            e.wgt = w;
            if (clr) begin
                m_acc_u = '0;
                m_acc_s = '0;
            end else begin
                m_acc_u = m_acc_u + prod_u(a, w);
                m_acc_s = m_acc_s + prod_s(a, w);
            end
        end
        e.acc_u = m_acc_u;
        e.acc_s = m_acc_s;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: the PE presents a fresh output after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("u_active_o", DW_OUT'(u_active_o), DW_OUT'(e.act));
                cmp("u_weight_o", DW_OUT'(u_weight_o), DW_OUT'(e.wgt));
                cmp("u_mac_res_o", u_mac, e.acc_u);
                cmp("s_active_o", DW_OUT'(s_active_o), DW_OUT'(e.act));
                cmp("s_weight_o", DW_OUT'(s_weight_o), DW_OUT'(e.wgt));
                cmp("s_mac_res_o", s_mac, e.acc_s);
            end
        end
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for two edges with nonzero inputs
        step(1'b1, 1'b0, 16'd5, 16'd7);
        step(1'b1, 1'b0, 16'd5, 16'd7);
        cmp("reset_active_o", DW_OUT'(u_active_o), 32'd0);
        cmp("reset_mac_res_o", u_mac, 32'd0);
        step(1'b0, 1'b0, 16'd5, 16'd7);
        cmp("post_reset_active_o", DW_OUT'(u_active_o), 32'd5);
        cmp("post_reset_weight_o", DW_OUT'(u_weight_o), 32'd7);

        // Basic MAC after a one-cycle clear
        step(1'b0, 1'b1, 16'd0, 16'd0);
        step(1'b0, 1'b0, 16'd0, 16'd1);
        cmp("mac_0", u_mac, 32'd0);
        step(1'b0, 1'b0, 16'd1, 16'd2);
        cmp("mac_2", u_mac, 32'd2);
        step(1'b0, 1'b0, 16'd2, 16'd3);
        cmp("mac_8", u_mac, 32'd8);
        step(1'b0, 1'b0, 16'd3, 16'd4);
        cmp("mac_20", u_mac, 32'd20);

        // Clear discards the current product, forwarding continues
        step(1'b0, 1'b1, 16'd3, 16'd4);
        cmp("clear_mac", u_mac, 32'd0);
        cmp("clear_active_o", DW_OUT'(u_active_o), 32'd3);
        step(1'b0, 1'b0, 16'd1, 16'd1);
        cmp("after_clear_mac", u_mac, 32'd1);

        // Clear held for several cycles
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'(i + 7), 16'(i + 9));
        cmp("held_clear_mac", u_mac, 32'd0);
        cmp("held_clear_weight_o", DW_OUT'(u_weight_o), 32'd12);

        // Reset beats clear with accumulator at 20
        step(1'b0, 1'b1, 16'd0, 16'd0);
        step(1'b0, 1'b0, 16'd0, 16'd1);
        step(1'b0, 1'b0, 16'd1, 16'd2);
        step(1'b0, 1'b0, 16'd2, 16'd3);
        step(1'b0, 1'b0, 16'd3, 16'd4);
        step(1'b1, 1'b1, 16'd9, 16'd9);
        cmp("prio_mac", u_mac, 32'd0);
        cmp("prio_active_o", DW_OUT'(u_active_o), 32'd0);
        cmp("prio_weight_o", DW_OUT'(u_weight_o), 32'd0);

        // Wrap modulo 2^32 on the unsigned instance
        step(1'b0, 1'b1, 16'd0, 16'd0);
        step(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        cmp("wrap_preload", u_mac, 32'hFFFE0001);
        step(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        cmp("wrap_sum", u_mac, 32'hFFFC0002);

        // Signed accumulation on the signed instance
        step(1'b0, 1'b1, 16'd0, 16'd0);
        step(1'b0, 1'b0, 16'hFFFD, 16'd4);
        cmp("signed_m12", s_mac, 32'hFFFFFFF4);
        step(1'b0, 1'b0, 16'd2, 16'hFFFB);
        cmp("signed_m22", s_mac, 32'hFFFFFFEA);

        // Randomized traffic with occasional clears and resets
        for (int i = 0; i < 400; i++) begin
            logic r, c;
            logic [DW_IN-1:0] a, w;
            r = ($urandom_range(0, 49) == 0);
            c = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       begin a = 16'hFFFF; w = 16'($urandom); end
                1:       begin a = 16'h8000; w = 16'h8000; end
                default: begin a = 16'($urandom); w = 16'($urandom); end
            endcase
            step(r, c, a, w);
        end

        step(1'b0, 1'b0, 16'd0, 16'd0);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_os.md
Name:
pe_os

Overview:
- Output-stationary processing element (PE) for a systolic matrix-multiply array.
- Each cycle it multiplies the incoming activation by the incoming weight and adds the product into a local accumulator that stays in place.
- It forwards the activation to its right-hand neighbour and the weight to its lower neighbour through one register stage each.
- The array controller uses `clear_i` to zero the accumulator between output tiles.

Parameters:
- DATA_WIDTH_IN, 16: width of the activation and weight operands, and of their forwarded copies.
- DATA_WIDTH_OUT, 32: width of the accumulator and of `mac_res_o`. Must satisfy DATA_WIDTH_OUT >= 2*DATA_WIDTH_IN; elaboration fails otherwise.
- SIGNED, 0: 0 = operands are unsigned, product is zero-extended. 1 = operands are two's complement, product is sign-extended.

Ports:
- clk_i, input, 1: the single clock; all state updates on its rising edge.
- rst_i, input, 1: synchronous, active-high reset.
- clear_i, input, 1: synchronous accumulator clear, active-high.
- active_i, input, DATA_WIDTH_IN: activation from the left neighbour or array edge.
- weight_i, input, DATA_WIDTH_IN: weight from the upper neighbour or array edge.
- active_o, output, DATA_WIDTH_IN: registered copy of `active_i`, to the right neighbour.
- weight_o, output, DATA_WIDTH_IN: registered copy of `weight_i`, to the lower neighbour.
- mac_res_o, output, DATA_WIDTH_OUT: current accumulator value, driven directly from a register.

Behaviour:
- Reset: when `rst_i`=1 at a rising edge, `active_o`, `weight_o` and the accumulator all become 0. Reset overrides everything else.
- Forwarding, every non-reset edge:
  - `active_o` <= `active_i`; `weight_o` <= `weight_i`.
  - Latency is exactly 1 cycle.
  - Forwarding is independent of `clear_i`.
- Product:
  - p = `active_i` * `weight_i` at full 2*DATA_WIDTH_IN width.
  - p is computed combinationally from the current inputs, not the forwarded registers.
  - p is extended to DATA_WIDTH_OUT according to SIGNED.
- Accumulator, on non-reset edges:
  - `clear_i`=1: acc <= 0. The current product is discarded, not loaded.
  - `clear_i`=0: acc <= acc + p, computed modulo 2^DATA_WIDTH_OUT.
  - No saturation and no overflow flag; the sum silently wraps.
- Latency: an operand pair presented before edge N appears in `mac_res_o` after edge N.
- `mac_res_o` has no combinational path from any input.
- Simultaneous events:
  - `rst_i` and `clear_i` both high: reset behaviour.
  - `clear_i` held high for many cycles: acc stays 0 while forwarding continues.
- Reset mid-accumulation discards the partial sum; accumulation restarts from 0 on the first edge with `rst_i`=0 and `clear_i`=0.
- Multiplier shall be a single-cycle, purely combinational stage with no internal pipelining, so the 1-cycle latency above holds.

Test Plan:
- Reset: hold `rst_i`=1 for 2 cycles with `active_i`=5, `weight_i`=7 -> `active_o`=0, `weight_o`=0, `mac_res_o`=0. After release, the next edge gives `active_o`=5, `weight_o`=7.
- Basic MAC, SIGNED=0, `clear_i` dropped one cycle earlier:
  - Drive (0,1), (1,2), (2,3), (3,4) on consecutive edges.
  - 1 cycle after each pair: `active_o`/`weight_o` = 0/1, 1/2, 2/3, 3/4.
  - `mac_res_o` = 0, 2, 8, 20 at the same points.
- Clear: after the accumulator reaches 20, assert `clear_i` for 1 cycle with inputs (3,4) -> `mac_res_o`=0 and `active_o`=3. Deassert `clear_i` with (1,1) -> `mac_res_o`=1 on the next edge.
- Priority: `rst_i`=1 and `clear_i`=1 with accumulator at 20 and inputs (9,9) -> all outputs 0 next edge.
- Wrap, default widths:
  - Preload: accumulate 0xFFFF*0xFFFF = 0xFFFE0001 (SIGNED=0).
  - Add 0xFFFF*0xFFFF again -> `mac_res_o` = 0xFFFC0002 (modulo 2^32).
- Signed, SIGNED=1: from cleared, drive (-3,4) -> `mac_res_o` = 0xFFFFFFF4 (-12). Then (2,-5) -> 0xFFFFFFEA (-22).
